maze_map_arbiter: RTL

- Shares the single-port, synchronously-read maze map memory among three requesters: the VGA pixel fetch (vga_subsystem world_pixel path), the ball collision lookup (Ball module), and the level loader write port.
- VGA has absolute priority, because video timing cannot stall. Collision and write requests are round-robin arbitrated in the remaining slots.
- Read data is returned to the requester that issued the read, at a fixed latency.

---
 rtl/maze_map_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/maze_map_arbiter.sv
// Shares the single-port maze map RAM between VGA fetch, collision lookup and level-loader writes.
// Latency: command registered one cycle after grant; read data returned MEM_LAT+2 cycles after grant.
// Backpressure: VGA is never refused; col/wr hold their request until granted (round-robin between them).
module maze_map_arbiter #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 2,
    parameter int MEM_LAT = 1,
    parameter int STALL_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              col_req,
    input  logic [ADDR_W-1:0] col_addr,
    output logic              col_gnt,
    output logic              col_rvalid,
    output logic [DATA_W-1:0] col_rdata,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [STALL_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {SEL_NONE, SEL_VGA, SEL_COL, SEL_WR} sel_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_VGA, TAG_COL} tag_t;
    typedef enum logic {SRV_COL, SRV_WR} srv_t;

    sel_t sel;
    srv_t last_srv;
    tag_t tag_in;
    tag_t tag_q [0:MEM_LAT];
    logic stall;

    // Grants are suppressed while reset is high so every output reads 0 in reset.
    always_comb begin
        sel = SEL_NONE;
        if (!reset) begin
            if (vga_req) begin
                sel = SEL_VGA;
            end else if (col_req && wr_req) begin
                sel = (last_srv == SRV_WR) ? SEL_COL : SEL_WR;
            end else if (col_req) begin
                sel = SEL_COL;
            end else if (wr_req) begin
                sel = SEL_WR;
            end
        end
    end

    always_comb begin
        tag_in = TAG_NONE;
        case (sel)
            SEL_VGA: tag_in = TAG_VGA;
            SEL_COL: tag_in = TAG_COL;
            default: tag_in = TAG_NONE;
        endcase
    end

    assign col_gnt = (sel == SEL_COL);
    assign wr_gnt  = (sel == SEL_WR);
    assign stall   = (col_req && !col_gnt) || (wr_req && !wr_gnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            last_srv  <= SRV_WR;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            case (sel)
                SEL_VGA: begin
                    mem_en   <= 1'b1;
                    mem_addr <= vga_addr;
                end
                SEL_COL: begin
                    mem_en   <= 1'b1;
                    mem_addr <= col_addr;
                    last_srv <= SRV_COL;
                end
                SEL_WR: begin
                    mem_en    <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_addr  <= wr_addr;
                    mem_wdata <= wr_data;
                    last_srv  <= SRV_WR;
                end
                default: ;
            endcase
        end
    end

    // Tag stage MEM_LAT lines up with mem_rdata for the read issued MEM_LAT+1 edges earlier.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= MEM_LAT; i++) begin
                tag_q[i] <= TAG_NONE;
            end
        end else begin
            tag_q[0] <= tag_in;
            for (int i = 1; i <= MEM_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_rvalid <= 1'b0;
            vga_rdata  <= '0;
            col_rvalid <= 1'b0;
            col_rdata  <= '0;
        end else begin
            vga_rvalid <= (tag_q[MEM_LAT] == TAG_VGA);
            col_rvalid <= (tag_q[MEM_LAT] == TAG_COL);
            if (tag_q[MEM_LAT] == TAG_VGA) begin
                vga_rdata <= mem_rdata;
            end
            if (tag_q[MEM_LAT] == TAG_COL) begin
                col_rdata <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {STALL_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(STALL_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
